// File: rtl/csi_frame_averager.sv
// csi_frame_averager
//   Coherent averager for the CSI extractor's per-subcarrier stream. It sums
//   2^LOG2_AVG consecutive well-formed N_SC-beat frames per subcarrier and
//   per I/Q component. It then drains one averaged N_SC-beat frame on an
//   AXI-Stream master. Malformed frames abort the current window and are counted.
//
// Ports
//   clk_in              single clock
//   rst_in              asynchronous, active-low reset
//   csi_axis_*          input stream, tdata = {re, im}, signed
//   avg_axis_*          averaged output stream, tdata = {re, im}, signed
//   frame_err_out       one-cycle pulse per malformed input frame
//   frames_dropped_out  saturating count of malformed input frames
module csi_frame_averager #(
  parameter int N_SC     = 64,
  parameter int LOG2_AVG = 2,
  parameter int DATA_W   = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                csi_axis_tvalid,
  input  logic                csi_axis_tlast,
  input  logic [2*DATA_W-1:0] csi_axis_tdata,
  output logic                csi_axis_tready,
  output logic                avg_axis_tvalid,
  output logic                avg_axis_tlast,
  output logic [2*DATA_W-1:0] avg_axis_tdata,
  input  logic                avg_axis_tready,
  output logic                frame_err_out,
  output logic [15:0]         frames_dropped_out
);

  // Extra LOG2_AVG bits make the window sum overflow-free.
  localparam int ACC_W = DATA_W + LOG2_AVG;
  localparam int IDX_W = (N_SC > 1) ? $clog2(N_SC) : 1;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_SC - 1);
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'((1 << LOG2_AVG) - 1);

  typedef enum logic [1:0] {ST_ACCUM, ST_SKIP, ST_DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    sc_idx_reg, sc_idx_next;
  logic [CNT_W-1:0]    frame_cnt_reg, frame_cnt_next;
  logic [IDX_W-1:0]    rd_idx_reg, rd_idx_next;
  logic                in_ready_reg;
  logic                out_valid_reg, out_valid_next;
  logic                out_last_reg, out_last_next;
  logic [2*DATA_W-1:0] out_data_reg, out_data_next;
  logic                err_reg, err_next;
  logic [15:0]         dropped_reg;

  logic                in_fire, out_fire, at_last;
  logic                acc_we, load_out;
  logic [IDX_W-1:0]    load_idx;
  logic signed [DATA_W-1:0] in_re, in_im, avg_re, avg_im;
  logic signed [ACC_W-1:0]  sum_re, sum_im, rd_re, rd_im;
  logic signed [ACC_W-1:0]  acc_re_rd [N_SC];
  logic signed [ACC_W-1:0]  acc_im_rd [N_SC];

  assign in_fire  = csi_axis_tvalid && in_ready_reg;
  assign out_fire = out_valid_reg && avg_axis_tready;
  assign at_last  = (sc_idx_reg == LAST_IDX);
  assign in_re    = csi_axis_tdata[2*DATA_W-1:DATA_W];
  assign in_im    = csi_axis_tdata[DATA_W-1:0];

  // The first frame of a window overwrites, so stale contents never leak.
  assign sum_re = (frame_cnt_reg == '0) ? ACC_W'(in_re)
                                        : acc_re_rd[sc_idx_reg] + ACC_W'(in_re);
  assign sum_im = (frame_cnt_reg == '0) ? ACC_W'(in_im)
                                        : acc_im_rd[sc_idx_reg] + ACC_W'(in_im);

  // One accumulator entry per subcarrier, written only on its own beat.
  for (genvar gi = 0; gi < N_SC; gi++) begin : g_acc
    logic signed [ACC_W-1:0] re_q, im_q;
    always_ff @(posedge clk_in) begin
      if (acc_we && (sc_idx_reg == IDX_W'(gi))) begin
        re_q <= sum_re;
        im_q <= sum_im;
      end
    end
    assign acc_re_rd[gi] = re_q;
    assign acc_im_rd[gi] = im_q;
  end

  // Output beat 0 is loaded in the same cycle as the window's last write. The
  // bypass covers the case where that write targets the entry being loaded.
  assign rd_re  = (acc_we && (load_idx == sc_idx_reg)) ? sum_re : acc_re_rd[load_idx];
  assign rd_im  = (acc_we && (load_idx == sc_idx_reg)) ? sum_im : acc_im_rd[load_idx];
  assign avg_re = DATA_W'(rd_re >>> LOG2_AVG);
  assign avg_im = DATA_W'(rd_im >>> LOG2_AVG);
  assign out_data_next = load_out ? {avg_re, avg_im} : out_data_reg;

  always_comb begin
    state_next     = state_reg;
    sc_idx_next    = sc_idx_reg;
    frame_cnt_next = frame_cnt_reg;
    rd_idx_next    = rd_idx_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    err_next       = 1'b0;
    acc_we         = 1'b0;
    load_out       = 1'b0;
    load_idx       = rd_idx_reg;
    case (state_reg)
      ST_ACCUM: begin
        if (in_fire) begin
          acc_we = 1'b1;
          if (csi_axis_tlast && at_last) begin
            sc_idx_next    = '0;
            frame_cnt_next = frame_cnt_reg + CNT_W'(1);
            if (frame_cnt_reg == LAST_FRAME) begin
              state_next     = ST_DRAIN;
              rd_idx_next    = '0;
              load_idx       = '0;
              load_out       = 1'b1;
              out_valid_next = 1'b1;
              out_last_next  = (LAST_IDX == '0);
            end
          end else if (csi_axis_tlast || at_last) begin
            // Short or long frame: the whole window is abandoned.
            err_next       = 1'b1;
            sc_idx_next    = '0;
            frame_cnt_next = '0;
            if (!csi_axis_tlast) begin
              state_next = ST_SKIP;
            end
          end else begin
            sc_idx_next = sc_idx_reg + IDX_W'(1);
          end
        end
      end
      ST_SKIP: begin
        if (in_fire && csi_axis_tlast) begin
          state_next  = ST_ACCUM;
          sc_idx_next = '0;
        end
      end
      ST_DRAIN: begin
        if (out_fire) begin
          if (out_last_reg) begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
            frame_cnt_next = '0;
            state_next     = ST_ACCUM;
          end else begin
            rd_idx_next   = rd_idx_reg + IDX_W'(1);
            load_idx      = rd_idx_reg + IDX_W'(1);
            load_out      = 1'b1;
            out_last_next = ((rd_idx_reg + IDX_W'(1)) == LAST_IDX);
          end
        end
      end
      default: state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg     <= ST_ACCUM;
      sc_idx_reg    <= '0;
      frame_cnt_reg <= '0;
      rd_idx_reg    <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      err_reg       <= 1'b0;
      dropped_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      sc_idx_reg    <= sc_idx_next;
      frame_cnt_reg <= frame_cnt_next;
      rd_idx_reg    <= rd_idx_next;
      in_ready_reg  <= (state_next != ST_DRAIN);
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      out_data_reg  <= out_data_next;
      err_reg       <= err_next;
      if (err_next && (dropped_reg != 16'hFFFF)) begin
        dropped_reg <= dropped_reg + 16'd1;
      end
    end
  end

  assign csi_axis_tready    = in_ready_reg;
  assign avg_axis_tvalid    = out_valid_reg;
  assign avg_axis_tlast     = out_last_reg;
  assign avg_axis_tdata     = out_data_reg;
  assign frame_err_out      = err_reg;
  assign frames_dropped_out = dropped_reg;

endmodule

// File: tb/tb_csi_frame_averager.sv
// Testbench for csi_frame_averager.
//   A frame-level reference model checks every output beat. It works from the
//   input beats that were actually accepted, using integer sums and floor
//   division. A table of constant-frame windows and a ramp pattern check the
//   averages against hand-computed values. Further sequences cover malformed
//   frames, backpressure, and reset during drain.
module tb_csi_frame_averager;
  localparam int N_SC     = 64;
  localparam int LOG2_AVG = 2;
  localparam int DATA_W   = 16;
  localparam int NAVG     = 1 << LOG2_AVG;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        csi_axis_tvalid = 1'b0;
  logic        csi_axis_tlast  = 1'b0;
  logic [31:0] csi_axis_tdata  = '0;
  logic        csi_axis_tready;
  logic        avg_axis_tvalid, avg_axis_tlast;
  logic [31:0] avg_axis_tdata;
  logic        avg_axis_tready = 1'b1;
  logic        frame_err_out;
  logic [15:0] frames_dropped_out;

  csi_frame_averager #(.N_SC(N_SC), .LOG2_AVG(LOG2_AVG), .DATA_W(DATA_W)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .csi_axis_tvalid    (csi_axis_tvalid),
    .csi_axis_tlast     (csi_axis_tlast),
    .csi_axis_tdata     (csi_axis_tdata),
    .csi_axis_tready    (csi_axis_tready),
    .avg_axis_tvalid    (avg_axis_tvalid),
    .avg_axis_tlast     (avg_axis_tlast),
    .avg_axis_tdata     (avg_axis_tdata),
    .avg_axis_tready    (avg_axis_tready),
    .frame_err_out      (frame_err_out),
    .frames_dropped_out (frames_dropped_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    cur_len;
  bit    cur_bad;
  int    win_re [N_SC];
  int    win_im [N_SC];
  int    win_cnt;
  int    model_errs;
  int    seen_errs;
  int    out_frames;
  bit    err_due, valid_due;

  function automatic int floor_div(int s, int d);
    int q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void model_clear_window();
    for (int k = 0; k < N_SC; k++) begin
      win_re[k] = 0;
      win_im[k] = 0;
    end
    win_cnt = 0;
  endfunction

  function automatic void model_error();
    model_errs++;
    err_due = 1'b1;
    model_clear_window();
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    cur_len    = 0;
    cur_bad    = 1'b0;
    model_errs = 0;
    seen_errs  = 0;
    err_due    = 1'b0;
    valid_due  = 1'b0;
    model_clear_window();
  endfunction

  // One accepted input beat. A frame is the run of beats up to tlast. It is
  // good only when exactly N_SC long; an overlong frame is flagged on its
  // N_SC-th beat.
  function automatic void model_beat(int re, int im, bit last);
    beat_t b;
    if (!cur_bad) begin
      if (cur_len < N_SC) begin
        win_re[cur_len] += re;
        win_im[cur_len] += im;
      end
      cur_len++;
      if (!last && cur_len == N_SC) begin
        cur_bad = 1'b1;
        model_error();
      end
    end
    if (last) begin
      if (!cur_bad) begin
        if (cur_len != N_SC) begin
          model_error();
        end else begin
          win_cnt++;
          if (win_cnt == NAVG) begin
            for (int k = 0; k < N_SC; k++) begin
              b.data = {16'(floor_div(win_re[k], NAVG)), 16'(floor_div(win_im[k], NAVG))};
              b.last = (k == N_SC - 1);
              exp_q.push_back(b);
            end
            valid_due = 1'b1;
            model_clear_window();
          end
        end
      end
      cur_len = 0;
      cur_bad = 1'b0;
    end
  endfunction

  // Hand-computed expectation mode for output beats:
  //   0 = model only, 1 = constant (chk_re, chk_im), 2 = ramp (k+1, -(k+2)).
  int chk_mode = 0;
  int chk_re   = 0;
  int chk_im   = 0;
  int out_beat = 0;
  bit bp_en    = 1'b0;

  // ---------------- monitor: samples 1 ns before each rising edge ----------------
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  initial begin
    model_reset();
    forever begin
      @(negedge clk_in);
      #4;
      if (!rst_in) begin
        prev_stall = 1'b0;
        err_due    = 1'b0;
        valid_due  = 1'b0;
        out_beat   = 0;
        continue;
      end
      check("err_pulse", {31'd0, frame_err_out}, {31'd0, err_due});
      if (frame_err_out) seen_errs++;
      err_due = 1'b0;
      if (valid_due) check("valid_rise", {31'd0, avg_axis_tvalid}, 32'd1);
      valid_due = 1'b0;
      if (avg_axis_tvalid) check("in_ready_in_drain", {31'd0, csi_axis_tready}, 32'd0);
      if (prev_stall) begin
        check("stall_valid", {31'd0, avg_axis_tvalid}, 32'd1);
        check("stall_data", avg_axis_tdata, prev_data);
        check("stall_last", {31'd0, avg_axis_tlast}, {31'd0, prev_last});
      end
      prev_stall = avg_axis_tvalid && !avg_axis_tready;
      prev_data  = avg_axis_tdata;
      prev_last  = avg_axis_tlast;

      if (avg_axis_tvalid && avg_axis_tready) begin
        check("out_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          beat_t e;
          logic [31:0] tv;
          e = exp_q.pop_front();
          check("out_data", avg_axis_tdata, e.data);
          check("out_last", {31'd0, avg_axis_tlast}, {31'd0, e.last});
        end
        if (chk_mode != 0) begin
          logic [31:0] tv;
          if (chk_mode == 1) tv = {16'(chk_re), 16'(chk_im)};
          else               tv = {16'(out_beat + 1), 16'(-(out_beat + 2))};
          check("tbl_data", avg_axis_tdata, tv);
          check("tbl_last", {31'd0, avg_axis_tlast}, {31'd0, out_beat == N_SC - 1});
        end
        if (out_beat == N_SC - 1) begin
          out_frames++;
          $display("[TB] output frame %0d delivered, last beat %h", out_frames, avg_axis_tdata);
          out_beat = 0;
        end else begin
          out_beat++;
        end
      end

      if (csi_axis_tvalid && csi_axis_tready)
        model_beat(int'($signed(csi_axis_tdata[31:16])), int'($signed(csi_axis_tdata[15:0])),
                   csi_axis_tlast);
    end
  end

  // Output backpressure.
  initial begin
    forever begin
      @(negedge clk_in);
      avg_axis_tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // ---------------- drivers (called at a falling edge, return at one) ----------------
  task automatic send_beat(input int re, input int im, input bit last);
    int n = 0;
    bit acc;
    csi_axis_tvalid = 1'b1;
    csi_axis_tdata  = {16'(re), 16'(im)};
    csi_axis_tlast  = last;
    forever begin
      #4;
      acc = csi_axis_tready;
      @(negedge clk_in);
      if (acc) break;
      n++;
      if (n > 3000) begin
        n_tests++;
        n_fail++;
        $display("FAIL in_accept_timeout: tready low for %0d cycles, required 1", n);
        break;
      end
    end
    csi_axis_tvalid = 1'b0;
    csi_axis_tlast  = 1'b0;
  endtask

  // mode 0: constant (a, b); mode 1: ramp re=k+a, im=-(k+a); mode 2: random
  task automatic send_frame(input int len, input int mode, input int a, input int b, input bit gaps);
    int re, im;
    logic [15:0] r16, i16;
    for (int k = 0; k < len; k++) begin
      if (gaps && $urandom_range(0, 5) == 0) @(negedge clk_in);
      case (mode)
        0: begin re = a; im = b; end
        1: begin re = k + a; im = -(k + a); end
        default: begin
          r16 = 16'($urandom);
          i16 = 16'($urandom);
          re  = int'($signed(r16));
          im  = int'($signed(i16));
        end
      endcase
      send_beat(re, im, k == len - 1);
    end
    $display("[TB] input frame sent: len=%0d mode=%0d", len, mode);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || avg_axis_tvalid) && n < 5000) begin
      @(negedge clk_in);
      n++;
    end
    check("drain_complete", 32'(exp_q.size()), 32'd0);
    @(negedge clk_in);
  endtask

  // ---------------- table of constant-frame windows ----------------
  typedef struct packed {
    logic [3:0][15:0] r;
    logic [3:0][15:0] i;
    logic [15:0]      er;
    logic [15:0]      ei;
  } vec_t;

  vec_t tbl [6];

  function automatic vec_t mk(int r0, int r1, int r2, int r3,
                              int i0, int i1, int i2, int i3, int er, int ei);
    vec_t v;
    v.r[0] = 16'(r0); v.r[1] = 16'(r1); v.r[2] = 16'(r2); v.r[3] = 16'(r3);
    v.i[0] = 16'(i0); v.i[1] = 16'(i1); v.i[2] = 16'(i2); v.i[3] = 16'(i3);
    v.er   = 16'(er);
    v.ei   = 16'(ei);
    return v;
  endfunction

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = mk(100, 100, 100, 100, -100, -100, -100, -100, 100, -100);
    tbl[1] = mk(-32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767, -32768, 32767);
    tbl[2] = mk(-1, -1, -1, -2, 1, 1, 1, 2, -2, 1);
    tbl[3] = mk(3, 0, 0, 0, -3, 0, 0, 0, 0, -1);
    tbl[4] = mk(32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768, 32767, -32768);
    tbl[5] = mk(5, 6, 7, 8, -5, -6, -7, -8, 6, -7);

    // Reset values.
    #1 rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    #4;
    check("rst_in_ready", {31'd0, csi_axis_tready}, 32'd0);
    check("rst_out_valid", {31'd0, avg_axis_tvalid}, 32'd0);
    check("rst_out_last", {31'd0, avg_axis_tlast}, 32'd0);
    check("rst_out_data", avg_axis_tdata, 32'd0);
    check("rst_err", {31'd0, frame_err_out}, 32'd0);
    check("rst_dropped", {16'd0, frames_dropped_out}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("post_rst_in_ready", {31'd0, csi_axis_tready}, 32'd1);

    // Table-driven constant windows, backpressure on every other entry.
    for (int t = 0; t < 6; t++) begin
      bp_en    = (t % 2 == 1);
      chk_mode = 1;
      chk_re   = int'($signed(tbl[t].er));
      chk_im   = int'($signed(tbl[t].ei));
      for (int f = 0; f < NAVG; f++)
        send_frame(N_SC, 0, int'($signed(tbl[t].r[f])), int'($signed(tbl[t].i[f])), 1'b0);
      wait_idle();
    end

    // Ramp pattern: beat k averages to (k+1, -(k+2)).
    bp_en    = 1'b0;
    chk_mode = 2;
    for (int f = 0; f < NAVG; f++) send_frame(N_SC, 1, f, 0, 1'b0);
    wait_idle();
    chk_mode = 0;

    // Short frame after two good frames aborts the window.
    send_frame(N_SC, 2, 0, 0, 1'b0);
    send_frame(N_SC, 2, 0, 0, 1'b0);
    send_frame(41, 2, 0, 0, 1'b0);
    check("short_dropped", {16'd0, frames_dropped_out}, 32'd1);
    for (int f = 0; f < NAVG - 1; f++) send_frame(N_SC, 2, 0, 0, 1'b0);
    repeat (4) @(negedge clk_in);
    check("no_partial_output", {31'd0, avg_axis_tvalid}, 32'd0);
    send_frame(N_SC, 2, 0, 0, 1'b0);
    wait_idle();

    // Long frame: error on beat N_SC-1, rest swallowed, then a good window.
    send_frame(70, 2, 0, 0, 1'b0);
    check("long_dropped", {16'd0, frames_dropped_out}, 32'd2);
    bp_en = 1'b1;
    for (int f = 0; f < NAVG; f++) send_frame(N_SC, 2, 0, 0, 1'b1);
    wait_idle();

    // Reset in the middle of the drain.
    chk_mode = 1;
    chk_re   = 7;
    chk_im   = -9;
    for (int f = 0; f < NAVG; f++) send_frame(N_SC, 0, 7, -9, 1'b0);
    n = 0;
    while (out_beat < 10 && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    check("drain_started", {31'd0, out_beat >= 10}, 32'd1);
    #2 rst_in = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, avg_axis_tvalid}, 32'd0);
    check("mid_rst_out_data", avg_axis_tdata, 32'd0);
    check("mid_rst_in_ready", {31'd0, csi_axis_tready}, 32'd0);
    check("mid_rst_dropped", {16'd0, frames_dropped_out}, 32'd0);
    model_reset();
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("mid_rst_release_ready", {31'd0, csi_axis_tready}, 32'd1);
    chk_mode = 2;
    for (int f = 0; f < NAVG; f++) send_frame(N_SC, 1, f, 0, 1'b0);
    wait_idle();
    chk_mode = 0;

    // Randomized frames and lengths against the model, with backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      int len;
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 80)) : N_SC;
      send_frame(len, 2, 0, 0, 1'b1);
    end
    for (int f = 0; f < NAVG; f++) send_frame(N_SC, 2, 0, 0, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk_in);

    check("final_dropped", {16'd0, frames_dropped_out}, 32'(model_errs));
    check("final_err_pulses", 32'(seen_errs), 32'(model_errs));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csi_frame_averager.md
Name: csi_frame_averager

Overview:
- Sits directly downstream of the CSI extractor and consumes its per-subcarrier CSI stream.
- Input frames are N_SC beats, with tlast on the final beat.
- Coherently averages 2^LOG2_AVG consecutive well-formed CSI frames, per subcarrier and per I/Q component.
- Emits one averaged N_SC-beat frame on an AXI-Stream master. Malformed frames abort the current averaging window and are counted.

Parameters:
- N_SC, 64, subcarriers (beats) per CSI frame.
- LOG2_AVG, 2, log2 of frames averaged per output (4 frames at default; legal range 0..4).
- DATA_W, 16, width of each signed re/im component.

Ports:
- clk_in  input  1  single clock for all logic.
- rst_in  input  1  asynchronous, active-low reset.
- csi_axis_tvalid  input  1  input beat valid.
- csi_axis_tlast  input  1  last beat of input frame.
- csi_axis_tdata  input  32  {re[31:16], im[15:0]}, signed two's complement.
- csi_axis_tready  output  1  block accepts input beat.
- avg_axis_tvalid  output  1  averaged beat valid.
- avg_axis_tlast  output  1  last beat of averaged frame.
- avg_axis_tdata  output  32  {re[31:16], im[15:0]}, signed averaged CSI.
- avg_axis_tready  input  1  downstream accepts beat.
- frame_err_out  output  1  one-cycle pulse per malformed input frame.
- frames_dropped_out  output  16  saturating count of malformed frames.

Behaviour:
- Reset (rst_in low, asynchronous)
  - State ACCUM; sc_idx=0, frame_cnt=0.
  - csi_axis_tready=0 while in reset, 1 from the first cycle after release.
  - avg_axis_tvalid=0, avg_axis_tlast=0, avg_axis_tdata=0, frame_err_out=0, frames_dropped_out=0.
  - Accumulator contents need not be cleared; the first frame of each window overwrites them.
- Storage
  - Accumulator array of N_SC entries × 2 components.
  - Each component is DATA_W+LOG2_AVG bits, signed, so the sum can never overflow.
- Input handshake: a beat transfers when csi_axis_tvalid && csi_axis_tready. tready=1 only in ACCUM and SKIP.
- State ACCUM
  - Each transfer writes acc[sc_idx] = sample (if frame_cnt==0) or acc[sc_idx] + sample (otherwise), sign-extended. Then sc_idx++.
  - tlast with sc_idx==N_SC-1 (well-formed frame): sc_idx=0 and frame_cnt++.
    - If frame_cnt becomes 2^LOG2_AVG, go to DRAIN.
  - tlast with sc_idx<N_SC-1 (short frame): error. Set sc_idx=0, frame_cnt=0, stay in ACCUM.
  - No tlast at sc_idx==N_SC-1 (long frame): error. Set sc_idx=0, frame_cnt=0, go to SKIP.
  - On any error: frame_err_out pulses high for exactly one cycle (the cycle after the offending beat), and frames_dropped_out increments, saturating at 16'hFFFF.
  - The window being aborted, including its previously accumulated good frames, is discarded. Output is never produced from a partial window.
- State SKIP: accept and discard beats. On the transferred tlast beat, go to ACCUM with sc_idx=0.
- State DRAIN
  - csi_axis_tready=0.
  - Output beat k: re = acc[k].re >>> LOG2_AVG, im likewise. This is an arithmetic shift (floor), truncated to DATA_W.
  - avg_axis_tvalid rises the cycle after the final input beat of the window transfers.
  - avg_axis_tlast is high only on beat N_SC-1.
  - The output register holds tdata, tvalid and tlast stable while tvalid && !tready.
  - When the tlast beat transfers: tvalid=0 the next cycle, state ACCUM, frame_cnt=0, tready=1 the same next cycle.
- Throughput: with tready held high, one output beat per cycle; there are no bubbles inside an output frame.
- LOG2_AVG=0: behaves as a registered pass-through with frame validation, still buffered per frame.
- Reset mid-operation: asynchronous return to the reset values above. Any partial window or partial output frame is lost, with no tlast emitted.

Test Plan:
- Four frames, all beats {re=100, im=-100}, tready=1 → one 64-beat output of {100,-100}; tlast only on beat 63; tvalid rises 1 cycle after input beat 255.
- Frames where frame f, beat k has re=k+f and im=-(k+f), for f=0..3 → beat k outputs re=k+1 (floor of (4k+6)/4) and im=-(k+2) (floor of -(4k+6)/4).
- Negative extremes: four frames of {-32768, 32767} → output {-32768, 32767} with no overflow; re=-1,-1,-1,-2 → output -2 (floor).
- Random avg_axis_tready backpressure during DRAIN → data and tlast held stable while stalled; all 64 beats delivered in order; csi_axis_tready=0 throughout.
- Two good frames, then a frame with tlast at beat 40 → frame_err_out one-cycle pulse, frames_dropped_out=1; no output until 4 further good frames arrive.
- Frame of 70 beats (tlast on beat 69) → error at beat 63, beats 64..69 swallowed in SKIP; next 4 good frames produce a correct output. Separately, assert rst_in low mid-DRAIN → avg_axis_tvalid=0 immediately; after release, csi_axis_tready=1 and the next 4 frames average correctly.
